ppe_req_ctrl: RTL

Requester-side companion to the programmable priority encoder arbiters (flat or hierarchical). Holds a per-requester pending-request count, drives the arbiter `Req` vector, consumes the one-hot `Gnt` returned in the same cycle, and emits each grant as a registered index with a valid/ready handshake to the downstream consumer. One grant is retired per accepted cycle; back-pressure from the consumer suppresses `Req` so the arbiter's internal priority pointer never advances on a grant that is dropped.

---
 rtl/ppe_req_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/ppe_req_ctrl.sv
// Requester-side front end for the programmable priority encoder arbiters:
// per-requester pending counts, Req generation, and a registered grant output.
module ppe_req_ctrl #(
  parameter int N     = 64,
  parameter int LOG_N = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_push,
  output logic [N-1:0]     Req,
  input  logic [N-1:0]     Gnt,
  output logic             gnt_valid,
  output logic [LOG_N-1:0] gnt_idx,
  input  logic             gnt_ready,
  output logic [N-1:0]     full,
  output logic             overflow,
  output logic             gnt_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     nz;
  logic [N-1:0]     take;
  logic             load_ok;
  logic             gnt_onehot;
  logic             gnt_ok;
  logic [LOG_N-1:0] gnt_enc;

  logic             gnt_valid_q, gnt_valid_d;
  logic [LOG_N-1:0] gnt_idx_q, gnt_idx_d;
  logic             overflow_q, overflow_d;
  logic             gnt_err_q, gnt_err_d;

  // Req must not depend on Gnt, otherwise the arbiter forms a combinational loop.
  assign load_ok = !gnt_valid_q | gnt_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign nz[gi]   = (cnt_q[gi] != '0);
    assign full[gi] = (cnt_q[gi] == CNT_MAX);
    assign Req[gi]  = nz[gi] & load_ok;
  end

  assign gnt_onehot = (Gnt != '0) && ((Gnt & (Gnt - N'(1))) == '0);
  assign gnt_ok     = gnt_onehot && ((Gnt & nz) != '0);
  assign take       = (load_ok && gnt_ok) ? Gnt : '0;

  always_comb begin
    gnt_enc = '0;
    for (int i = 0; i < N; i++) begin
      if (Gnt[i]) gnt_enc = gnt_enc | LOG_N'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_push[i] && !take[i]) begin
        if (!full[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!req_push[i] && take[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    overflow_d  = overflow_q | (|(req_push & full & ~take));
    gnt_err_d   = gnt_err_q | (load_ok & (Gnt != '0) & !gnt_ok);
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    if (|take) begin
      gnt_valid_d = 1'b1;
      gnt_idx_d   = gnt_enc;
    end else if (gnt_valid_q && gnt_ready) begin
      gnt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      overflow_q  <= 1'b0;
      gnt_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      overflow_q  <= overflow_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign overflow  = overflow_q;
  assign gnt_err   = gnt_err_q;

endmodule
